// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit Wishbone master port among NUM_MASTERS requesters.
// A grant is held for a whole cyc tenure; an optional watchdog turns a hung access into err.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_MASTERS*32-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*32-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]      m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    output logic [31:0]                   m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [31:0]                   wbs_adr_o,
    output logic [31:0]                   wbs_dat_o,
    output logic [3:0]                    wbs_sel_o,
    output logic                          wbs_we_o,
    output logic                          wbs_stb_o,
    output logic                          wbs_cyc_o,
    input  logic [31:0]                   wbs_dat_i,
    input  logic                          wbs_ack_i,
    input  logic                          wbs_err_i,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                          busy_o
);

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   pick;
    logic [WW-1:0]   wd_q, wd_d;
    logic            busy, own_cyc, own_stb, wd_err;

    // Requesters above last win first (lowest index among them), otherwise wrap to the lowest.
    always_comb begin
        pick = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--)
            if (m_cyc_i[k] && k <= int'(last_q)) pick = GW'(k);
        for (int k = NUM_MASTERS - 1; k >= 0; k--)
            if (m_cyc_i[k] && k > int'(last_q)) pick = GW'(k);
    end

    assign busy    = (state_q == OWN);
    assign own_cyc = m_cyc_i[grant_q];
    assign own_stb = m_stb_i[grant_q];
    assign wd_err  = (TIMEOUT > 0) && busy && own_cyc && own_stb && (wd_q == WW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wd_d    = '0;
        case (state_q)
            IDLE: if (|m_cyc_i) begin
                state_d = OWN;
                grant_d = pick;
            end
            OWN: if (!own_cyc) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
        // Counts only unanswered strobe cycles; the cycle that fires the timeout restarts it.
        if ((TIMEOUT > 0) && busy && own_cyc && own_stb && !wbs_ack_i && !wbs_err_i && !wd_err)
            wd_d = wd_q + WW'(1);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_MASTERS - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Slave side is gated to zero whenever nobody owns the bus.
    always_comb begin
        wbs_adr_o = busy ? m_adr_i[32*grant_q +: 32] : '0;
        wbs_dat_o = busy ? m_dat_i[32*grant_q +: 32] : '0;
        wbs_sel_o = busy ? m_sel_i[4*grant_q +: 4]   : '0;
        wbs_we_o  = busy & m_we_i[grant_q];
        wbs_cyc_o = busy & own_cyc;
        wbs_stb_o = busy & own_cyc & own_stb & ~wd_err;
        m_ack_o   = '0;
        m_err_o   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (busy && grant_q == GW'(k) && m_cyc_i[k]) begin
                m_ack_o[k] = wbs_ack_i;
                m_err_o[k] = wbs_err_i | wd_err;
            end
        end
    end

    assign m_dat_o = wbs_dat_i;
    assign grant_o = grant_q;
    assign busy_o  = busy;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: masters issue queued tenures, completions are
// matched in order against expected owner, bus fields and timing.
module tb_wb_rr_arbiter;
    localparam int NM = 2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic wb_rst_i;
    logic [NM*32-1:0] madr, mdat;
    logic [NM*4-1:0]  msel;
    logic [NM-1:0]    mwe, mstb, mcyc;
    logic [31:0]      m_dat_o, wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [NM-1:0]    m_ack_o, m_err_o;
    logic [3:0]       wbs_sel_o;
    logic             wbs_we_o, wbs_stb_o, wbs_cyc_o, wbs_ack_i, wbs_err_i, busy_o;
    logic [0:0]       grant_o;
    logic [1:0]       smode;   // 0: never answer, 1: ack, 2: err

    always #5 clk = ~clk;

    wb_rr_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .m_adr_i(madr), .m_dat_i(mdat), .m_sel_i(msel), .m_we_i(mwe),
        .m_stb_i(mstb), .m_cyc_i(mcyc), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .grant_o(grant_o), .busy_o(busy_o)
    );

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    assign wbs_dat_i = slave_rd(wbs_adr_o);
    assign wbs_ack_i = (smode == 2'd1) & wbs_stb_o;
    assign wbs_err_i = (smode == 2'd2) & wbs_stb_o;

    typedef struct {logic [31:0] adr, dat; logic [3:0] sel; logic we;} req_t;
    typedef struct {int m; logic [31:0] adr, dat; logic [3:0] sel; logic we, err, wdto;} exp_t;

    req_t mq[NM][$];
    exp_t sb[$];
    logic [NM-1:0] act, done;
    int nchk = 0, nerr = 0, stbcnt = 0, idle_run = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int m, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic err, input logic wdto);
        req_t r;
        exp_t e;
        r.adr = adr; r.dat = dat; r.sel = sel; r.we = we;
        mq[m].push_back(r);
        e.m = m; e.adr = adr; e.dat = dat; e.sel = sel; e.we = we; e.err = err; e.wdto = wdto;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        if (busy_o && mstb[grant_o]) stbcnt++; else stbcnt = 0;
        if (!busy_o) begin
            chk("idle_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, m_ack_o, m_err_o}, 0);
            chk("idle_adr", {wbs_adr_o, wbs_dat_o}, 0);
            if (|mcyc) idle_run++;
        end else if (idle_run != 0) begin
            chk("idle_gap", idle_run, 1);
            idle_run = 0;
        end
        if ((m_ack_o | m_err_o) != '0) begin
            done = m_ack_o | m_err_o;
            if (sb.size() == 0) chk("unexpected", {m_err_o, m_ack_o}, 0);
            else begin
                e = sb.pop_front();
                chk("grant", grant_o, e.m);
                chk("ack_err", {m_err_o, m_ack_o}, e.err ? (64'd1 << (e.m + NM)) : (64'd1 << e.m));
                chk("adr", wbs_adr_o, e.adr);
                chk("we_sel", {wbs_we_o, wbs_sel_o}, {e.we, e.sel});
                chk("stb", wbs_stb_o, !e.wdto);
                chk("nstb", stbcnt, e.wdto ? TO + 1 : 1);
                if (e.we) chk("wdat", wbs_dat_o, e.dat);
                else if (!e.err) chk("rdat", m_dat_o, slave_rd(e.adr));
            end
            stbcnt = 0;
        end
    endtask

    task automatic drive();
        req_t r;
        for (int m = 0; m < NM; m++) begin
            if (done[m]) begin
                done[m] = 1'b0; act[m] = 1'b0;
                mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0;
                madr[32*m +: 32] = '0; mdat[32*m +: 32] = '0; msel[4*m +: 4] = '0;
            end else if (!act[m] && mq[m].size() != 0) begin
                r = mq[m].pop_front();
                act[m] = 1'b1;
                mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = r.we;
                madr[32*m +: 32] = r.adr; mdat[32*m +: 32] = r.dat; msel[4*m +: 4] = r.sel;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int maxc);
        int i = 0;
        while ((sb.size() != 0 || mq[0].size() != 0 || mq[1].size() != 0 || act != '0) && i < maxc) begin
            step();
            i++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wb_rst_i = 1'b1; smode = 2'd1;
        madr = '0; mdat = '0; msel = '0; mwe = '0; mstb = '0; mcyc = '0;
        act = '0; done = '0;
        #12;
        chk("rst_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, busy_o, grant_o, m_ack_o, m_err_o}, 0);
        chk("rst_bus", {wbs_adr_o, wbs_dat_o}, 0);
        @(negedge clk) wb_rst_i = 1'b0;

        // Simultaneous requests after reset: M0 wins, then M1 after one idle cycle.
        issue(0, 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
        issue(1, 32'h200, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
        run(50);

        // Both masters keep requesting: grants alternate.
        for (int i = 0; i < 3; i++) begin
            issue(0, 32'h1000 + 32'(i * 4), 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
            issue(1, 32'h2000 + 32'(i * 4), 1'b1, $urandom, 4'hF, 1'b0, 1'b0);
        end
        run(100);

        // Partial-byte write from M1.
        issue(1, 32'h40, 1'b1, 32'h12345678, 4'b0011, 1'b0, 1'b0);
        run(30);

        // Silent slave: watchdog err on the fifth strobe cycle.
        smode = 2'd0;
        issue(0, 32'h80, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1);
        run(40);

        // Slave error reported same cycle.
        smode = 2'd2;
        issue(1, 32'h90, 1'b1, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
        run(30);

        // Reset in the middle of a tenure.
        smode = 2'd0;
        begin
            req_t r;
            r.adr = 32'h300; r.dat = '0; r.sel = 4'hF; r.we = 1'b0;
            mq[1].push_back(r);
        end
        step(); step(); step();
        #3;
        chk("pre_rst_busy", {busy_o, wbs_cyc_o}, 2'b11);
        wb_rst_i = 1'b1;
        #1;
        chk("mid_rst", {wbs_cyc_o, wbs_stb_o, busy_o, grant_o, m_ack_o, m_err_o}, 0);
        act = '0; done = '0; mcyc = '0; mstb = '0; mwe = '0;
        madr = '0; mdat = '0; msel = '0;
        mq[1].delete();
        idle_run = 0; stbcnt = 0;
        @(negedge clk) wb_rst_i = 1'b0;
        smode = 2'd1;
        issue(0, 32'h500, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
        issue(1, 32'h600, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
        run(50);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
